// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller: phase encoding,
// lamp one-hot patterns, default durations and the phase ordering helpers.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5
  } phase_t;

  // Lamp bits are {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int unsigned DEF_YELLOW_T  = 3;
  localparam int unsigned DEF_ALLRED_T  = 1;
  localparam int unsigned DEF_MIN_GREEN = 5;
  localparam int unsigned DEF_MAX_GREEN = 60;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = RED_A;
      RED_A:     n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = RED_B;
      RED_B:     n = NS_GREEN;
      default:   n = RED_B;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] ns_lamp(input phase_t p);
    logic [2:0] l;
    case (p)
      NS_GREEN:  l = LAMP_GRN;
      NS_YELLOW: l = LAMP_YEL;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_t p);
    logic [2:0] l;
    case (p)
      EW_GREEN:  l = LAMP_GRN;
      EW_YELLOW: l = LAMP_YEL;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

  function automatic logic is_green(input phase_t p);
    return (p == NS_GREEN) || (p == EW_GREEN);
  endfunction

endpackage

// File: rtl/green_clamp.sv
// Combinational unsigned 8-bit clamp of a requested green duration into
// the [MIN_GREEN, MAX_GREEN] window.
module green_clamp
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN = DEF_MAX_GREEN
) (
  input  logic [7:0] green_time,
  output logic [7:0] clamped
);

  localparam logic [7:0] LO = 8'(MIN_GREEN);
  localparam logic [7:0] HI = 8'(MAX_GREEN);

  always_comb begin
    clamped = green_time;
    if (green_time < LO) begin
      clamped = LO;
    end else if (green_time > HI) begin
      clamped = HI;
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Six-phase two-road intersection sequencer. Phase advance and countdown are
// gated by the 1 Hz tick enable; lamps are registered alongside the phase.
module light_sequencer
  import tlc_pkg::*;
#(
  parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
  parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN = DEF_MAX_GREEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic [7:0] ns_green_time,
  input  logic [7:0] ew_green_time,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase,
  output logic [7:0] remaining,
  output logic       sample
);

  localparam logic [7:0] YEL_LOAD = 8'(YELLOW_T);
  localparam logic [7:0] RED_LOAD = 8'(ALLRED_T);

  phase_t     phase_q;
  phase_t     phase_nxt;
  logic [7:0] remaining_q;
  logic [7:0] clamp_in;
  logic [7:0] clamp_out;
  logic [7:0] load_val;
  logic       step;
  logic       expire;
  logic       legal;

  green_clamp #(
    .MIN_GREEN(MIN_GREEN),
    .MAX_GREEN(MAX_GREEN)
  ) u_green_clamp (
    .green_time(clamp_in),
    .clamped   (clamp_out)
  );

  always_comb begin
    phase_nxt = next_phase(phase_q);
    clamp_in  = (phase_nxt == EW_GREEN) ? ew_green_time : ns_green_time;
    case (phase_nxt)
      NS_GREEN, EW_GREEN:   load_val = clamp_out;
      NS_YELLOW, EW_YELLOW: load_val = YEL_LOAD;
      default:              load_val = RED_LOAD;
    endcase
    step   = tick && run;
    expire = (remaining_q <= 8'd1);
    legal  = (phase_q <= RED_B);
  end

  // Lamps are registered from the next phase so they change on the same edge
  // as the phase register, matching a decode of the registered phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= RED_B;
      remaining_q <= RED_LOAD;
      ns_light    <= LAMP_RED;
      ew_light    <= LAMP_RED;
      sample      <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (!legal) begin
        phase_q     <= RED_B;
        remaining_q <= RED_LOAD;
        ns_light    <= LAMP_RED;
        ew_light    <= LAMP_RED;
      end else if (step) begin
        if (expire) begin
          phase_q     <= phase_nxt;
          remaining_q <= load_val;
          ns_light    <= ns_lamp(phase_nxt);
          ew_light    <= ew_lamp(phase_nxt);
          sample      <= is_green(phase_nxt);
        end else begin
          remaining_q <= remaining_q - 8'd1;
        end
      end
    end
  end

  assign phase     = phase_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Randomized self-checking bench for light_sequencer against a table-driven
// phase/duration model.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       run = 1'b1;
  logic [7:0] ns_green_time = 8'd30;
  logic [7:0] ew_green_time = 8'd20;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [7:0] remaining;
  logic       sample;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  int unsigned m_phase = 5;
  int unsigned m_rem   = 1;
  int unsigned m_sample = 0;
  int unsigned ns_tab [6] = '{1, 2, 4, 4, 4, 4};
  int unsigned ew_tab [6] = '{4, 4, 4, 1, 2, 4};

  light_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .run          (run),
    .ns_green_time(ns_green_time),
    .ew_green_time(ew_green_time),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .phase        (phase),
    .remaining    (remaining),
    .sample       (sample)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned clampg(input int unsigned g);
    if (g < 5) return 5;
    if (g > 60) return 60;
    return g;
  endfunction

  function automatic int unsigned dur(input int unsigned p);
    case (p)
      0: return clampg(ns_green_time);
      3: return clampg(ew_green_time);
      1, 4: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic compare_all();
    check("phase", phase, m_phase);
    check("remaining", remaining, m_rem);
    check("ns_light", ns_light, ns_tab[m_phase]);
    check("ew_light", ew_light, ew_tab[m_phase]);
    check("sample", sample, m_sample);
  endtask

  // Entered at a negedge; leaves at the following negedge after checking.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    m_sample = 0;
    if (t && run) begin
      if (m_rem > 1) m_rem--;
      else begin
        m_phase = (m_phase + 1) % 6;
        m_rem = dur(m_phase);
        m_sample = (m_phase == 0 || m_phase == 3) ? 1 : 0;
      end
    end
    #1 tick = 1'b0;
    @(negedge clk);
    compare_all();
  endtask

  task automatic tk();
    cyc(1'b1);
    repeat ($urandom_range(0, 2)) cyc(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_phase = 5;
    m_rem = 1;
    m_sample = 0;
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_until(input int unsigned p, input int unsigned r);
    bit found = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_phase == p && m_rem == r) begin
        found = 1;
        break;
      end
      tk();
    end
    if (!found) check("run_until_timeout", 0, 1);
  endtask

  task automatic measure(input string tag, input int unsigned p, input int unsigned exp);
    int unsigned cnt = 0;
    do begin
      tk();
      cnt++;
    end while (phase == 3'(p) && cnt < 100);
    check(tag, cnt, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("safety_both_nonred", (ns_light != 3'b100) && (ew_light != 3'b100), 0);
      check("lamp_onehot", $onehot(ns_light) && $onehot(ew_light), 1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and first tick
    ns_green_time = 8'd30;
    ew_green_time = 8'd20;
    run = 1'b1;
    @(negedge clk);
    do_reset();
    cyc(1'b1);
    check("first_entry_phase", phase, 0);
    check("first_entry_rem", remaining, 30);
    check("first_entry_sample", sample, 1);
    cyc(1'b0);

    // Mid-green input change is ignored until the next NS entry
    run_until(0, 10);
    ns_green_time = 8'd60;
    repeat (10) tk();
    check("midgreen_end_phase", phase, 1);
    run_until(0, 60);
    check("ns_reload_60", remaining, 60);

    // Phase lengths
    ns_green_time = 8'd50;
    ew_green_time = 8'd20;
    do_reset();
    tk();
    measure("ns_green_len", 0, 50);
    measure("ns_yellow_len", 1, 3);
    measure("red_a_len", 2, 1);
    measure("ew_green_len", 3, 20);

    // Freeze: run low suppresses ticks
    run_until(4, 2);
    run = 1'b0;
    repeat (5) cyc(1'b1);
    check("freeze_phase", phase, 4);
    check("freeze_rem", remaining, 2);
    run = 1'b1;
    tk();
    tk();
    check("unfreeze_red_b", phase, 5);

    // Clamping
    ns_green_time = 8'd0;
    ew_green_time = 8'd200;
    do_reset();
    tk();
    check("clamp_min", remaining, 5);
    run_until(2, 1);
    cyc(1'b1);
    check("clamp_max", remaining, 60);
    ew_green_time = 8'd255;
    run_until(2, 1);
    cyc(1'b1);
    check("clamp_255", remaining, 60);

    // Asynchronous reset mid EW_GREEN
    run_until(3, 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_phase", phase, 5);
    check("async_rem", remaining, 1);
    check("async_ns", ns_light, 3'b100);
    check("async_ew", ew_light, 3'b100);
    check("async_sample", sample, 0);
    #1 rst = 1'b0;
    m_phase = 5;
    m_rem = 1;
    m_sample = 0;
    @(negedge clk);
    compare_all();

    // Randomized run/tick/green-time traffic
    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) ns_green_time = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ew_green_time = 8'($urandom_range(0, 255));
      cyc(1'($urandom_range(0, 1)));
    end
    run = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Timed phase sequencer for the two-road intersection. Consumes the rounded green durations produced by the `round` stage, one per road, in whole seconds. Drives the north-south (NS) and east-west (EW) lamp outputs through a fixed six-phase cycle. Advances only on a 1 Hz `tick` enable from the prescaler; all other logic runs on the system clock.

## Interface
- `YELLOW_T`, 3: yellow duration, in ticks.
- `ALLRED_T`, 1: all-red clearance duration, in ticks.
- `MIN_GREEN`, 5: lower clamp applied to a sampled green time.
- `MAX_GREEN`, 60: upper clamp applied to a sampled green time.
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-`clk`-wide 1 Hz enable.
- `run`  in  1  1 = sequence advances; 0 = freeze the current phase and count.
- `ns_green_time`  in  8  rounded NS green duration from `round`, unsigned seconds.
- `ew_green_time`  in  8  rounded EW green duration from `round`, unsigned seconds.
- `ns_light`  out  3  NS lamps, one-hot {red, yellow, green}.
- `ew_light`  out  3  EW lamps, one-hot {red, yellow, green}.
- `phase`  out  3  current phase encoding.
- `remaining`  out  8  ticks left in the current phase.
- `sample`  out  1  one-`clk` pulse on the edge where a green time is captured.

## Operation
- Phases cycle in this order: NS_GREEN → NS_YELLOW → RED_A → EW_GREEN → EW_YELLOW → RED_B → NS_GREEN.
- Phase encodings are 0 to 5 in that order.
- Lamps per phase:
  - NS_GREEN: NS = green, EW = red.
  - NS_YELLOW: NS = yellow, EW = red.
  - EW_GREEN: NS = red, EW = green.
  - EW_YELLOW: NS = red, EW = yellow.
  - RED_A and RED_B: both roads red.
- Exactly one lamp bit is set per road at all times. Both roads never show non-red in the same cycle.
- On entry to a phase, `remaining` loads that phase's duration:
  - Yellow phases: `YELLOW_T`.
  - Red phases: `ALLRED_T`.
  - Green phases: clamp(green_time, `MIN_GREEN`, `MAX_GREEN`).
- Green time is sampled on the entry edge only, from `ns_green_time` for NS_GREEN and `ew_green_time` for EW_GREEN. Input changes during green have no effect.
- `sample` is high for the one cycle after that capture edge.
- Clamping is an unsigned 8-bit compare. Input 0 gives `MIN_GREEN`; input 255 gives `MAX_GREEN`.
- Countdown:
  - On a cycle with `tick` = 1 and `run` = 1, with `remaining` > 1: decrement `remaining`.
  - On the same condition with `remaining` = 1: move to the next phase and load its duration.
  - Each phase therefore lasts exactly its duration in ticks.
- With `run` = 0, `tick` is ignored. Phase, lamps and `remaining` hold.
- An illegal phase encoding (6 or 7) recovers to RED_B with `remaining` = `ALLRED_T` on the next clock.

## Timing
- Reset values:
  - `phase` = RED_B (5), `remaining` = `ALLRED_T`.
  - `ns_light` = 3'b100, `ew_light` = 3'b100.
  - `sample` = 0.
- Asserting `rst` mid-phase forces these values immediately, without waiting for a clock edge.
- After reset is released, the first qualifying tick enters NS_GREEN (with `ALLRED_T` = 1).
- All outputs are registered. Lamps, `phase` and `remaining` change on the same `clk` edge that samples the qualifying `tick`. Lamp outputs are decoded from the registered phase.
- `sample` asserts in the cycle immediately after the entry edge to NS_GREEN or EW_GREEN.
- If `tick` is held high for several cycles, each high cycle counts as one tick. The bench must supply single-cycle pulses.
- `run` deasserting in the same cycle as a `tick` suppresses that tick.
- Minimum full cycle = 2·`MIN_GREEN` + 2·`YELLOW_T` + 2·`ALLRED_T` ticks = 18 ticks with the defaults.

## Structure
- Shared package `tlc_pkg` holds:
  - the phase enumeration and its 3-bit encoding;
  - the lamp one-hot constants `LAMP_RED`, `LAMP_YEL`, `LAMP_GRN`;
  - the default durations.
- `round` and the top level also import `tlc_pkg`.
- One sub-module, `green_clamp`: combinational 8-bit clamp parameterised by `MIN_GREEN` and `MAX_GREEN`. Instantiated once, with its input muxed by the next phase.
- The phase register, countdown counter and lamp decode stay in `light_sequencer`.

## Test plan
- Reset then release, `run` = 1, `ns_green_time` = 30:
  - `phase` = 5 and both lamps = 3'b100 before the first tick.
  - After tick 1: `phase` = 0, `remaining` = 30, `ns_light` = 3'b001, one `sample` pulse.
- Green length:
  - `ns_green_time` = 50, `ew_green_time` = 20.
  - NS green lasts exactly 50 ticks, then yellow for 3, all-red for 1, EW green for 20.
- Clamping:
  - `ns_green_time` = 0 gives `remaining` = 5 at NS_GREEN entry.
  - `ew_green_time` = 200 gives `remaining` = 60 at EW_GREEN entry.
- Input change mid-green:
  - Change `ns_green_time` from 30 to 60 at NS_GREEN `remaining` = 10.
  - The current green still ends after 10 more ticks.
  - The next NS_GREEN loads 60.
- Freeze:
  - Drop `run` at EW_YELLOW `remaining` = 2 and apply 5 ticks: no change.
  - Raise `run`: 2 more ticks reach RED_B.
- Asynchronous reset:
  - Pulse `rst` between clock edges during EW_GREEN.
  - Outputs take their reset values immediately, before the next `clk` edge.
  - A safety monitor checks on every cycle that NS and EW are never both non-red.
